// File: rtl/wbm_pkg.sv
// Shared types for the Wishbone master controller: FSM state and response status codes.
package wbm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_TIMEOUT = 2'd2
  } wbm_status_e;

endpackage

// File: rtl/wbm_timeout_cnt.sv
// Clear/enable saturating cycle counter; done_o flags the cycle whose closing edge is the
// TIMEOUT_CYCLES-th counted edge. TIMEOUT_CYCLES = 0 disables it (done_o stays 0).
module wbm_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Look one edge ahead so the abort lands exactly on the TIMEOUT_CYCLES-th edge after entry.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_on
      assign done_o = en_i && (cnt_q >= LAST);
    end else begin : g_off
      assign done_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone classic single-cycle master driven by a valid/ready command port, one registered
// response per command. Define WBM_ERR_EN to add the wbm_err_i port and drive rsp_err.
module wb_master_ctrl
  import wbm_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    wbm_clk_i,
  input  logic                    wbm_rst_i,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_timeout,
  output logic                    rsp_err,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
`ifdef WBM_ERR_EN
  input  logic                    wbm_err_i,
`endif
  input  logic                    wbm_ack_i
);

  localparam int SW = DATA_WIDTH / 8;

  wbm_state_e            state_q, state_d;
  wbm_status_e           status;
  logic                  err_w, to_done, accept, term;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

`ifdef WBM_ERR_EN
  assign err_w = wbm_err_i;
`else
  assign err_w = 1'b0;
`endif

  assign accept = (state_q == IDLE) && cmd_ready_q && cmd_valid;
  assign term   = err_w || wbm_ack_i || to_done;

  wbm_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i  (wbm_clk_i),
    .rst_i  (wbm_rst_i),
    .clr_i  (accept),
    .en_i   (state_q == BUS),
    .done_o (to_done)
  );

  always_ff @(posedge wbm_clk_i) begin
    if (wbm_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUS;
      BUS:     if (term) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Termination priority: err, then ack, then timeout.
  always_comb begin
    status = RSP_OK;
    if (err_w) begin
      status = RSP_ERR;
    end else if (!wbm_ack_i && to_done) begin
      status = RSP_TIMEOUT;
    end
  end

  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_to_d    = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = cmd_we;
          adr_d = cmd_addr;
          dat_d = cmd_we ? cmd_data : '0;
          sel_d = cmd_sel;
        end
      end
      BUS: begin
        if (term) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = '0;
          dat_d       = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (status == RSP_ERR);
          rsp_to_d    = (status == RSP_TIMEOUT);
          if ((status == RSP_OK) && !we_q) rsp_data_d = wbm_dat_i;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready   = cmd_ready_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_to_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Randomised scoreboard bench for wb_master_ctrl with a behavioural Wishbone slave.
module tb_wb_master_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8;
  localparam int T  = 16;
  localparam int NEVER = 1000;
`ifdef WBM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_sel;
  logic          rsp_valid, rsp_timeout, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_dat_i = '0;
  logic          wbm_ack_i = 1'b0;
  logic          wbm_err_i = 1'b0;

  always #5 clk = ~clk;

  wb_master_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .wbm_clk_i   (clk),
    .wbm_rst_i   (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_sel     (cmd_sel),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .rsp_err     (rsp_err),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_dat_i   (wbm_dat_i),
`ifdef WBM_ERR_EN
    .wbm_err_i   (wbm_err_i),
`endif
    .wbm_ack_i   (wbm_ack_i)
  );

  typedef struct {
    logic [DW-1:0] data;
    bit            to;
    bit            err;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   acc_edge = 0;

  // Transaction currently on the bus, as the slave should see it.
  int            cur_wait = 0;
  logic [DW-1:0] cur_rdata = '0;
  bit            cur_err = 1'b0;
  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_adr = '0;
  logic [DW-1:0] cur_dat = '0;
  logic [SW-1:0] cur_sel = '0;
  bit            spur_ack = 1'b0;
  int            wcnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave: checks bus stability every cycle of a cycle, acks after cur_wait wait states.
  always @(negedge clk) begin
    if (wbm_cyc_o) begin
      checks++;
      if (!(wbm_stb_o === 1'b1 && wbm_we_o === cur_we && wbm_adr_o === cur_adr &&
            wbm_sel_o === cur_sel && wbm_dat_o === (cur_we ? cur_dat : '0))) begin
        errors++;
        $display("FAIL wb_out: got stb=%0b we=%0b adr=%0h sel=%0h dat=%0h expected stb=1 we=%0b adr=%0h sel=%0h dat=%0h",
                 wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o,
                 cur_we, cur_adr, cur_sel, cur_we ? cur_dat : '0);
      end
      wbm_ack_i = (wcnt == cur_wait);
      wbm_err_i = (wcnt == cur_wait) && cur_err;
      wbm_dat_i = (wcnt == cur_wait) ? cur_rdata : $urandom;
      wcnt++;
    end else begin
      wbm_ack_i = spur_ack;
      wbm_err_i = spur_ack;
      wbm_dat_i = $urandom;
      wcnt = 0;
    end
  end

  // Monitor: every response must match the oldest outstanding expectation, on its cycle.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 data=%0h expected no response", rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_data !== mon_e.data || rsp_timeout !== mon_e.to || rsp_err !== mon_e.err ||
            cyc_cnt != mon_e.cyc || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
          errors++;
          $display("FAIL rsp: got data=%0h to=%0b err=%0b cycle=%0d cyc=%0b expected data=%0h to=%0b err=%0b cycle=%0d cyc=0",
                   rsp_data, rsp_timeout, rsp_err, cyc_cnt, wbm_cyc_o,
                   mon_e.data, mon_e.to, mon_e.err, mon_e.cyc);
        end
      end
    end
  end

  // Drive one command; wt >= T means the slave never acknowledges.
  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [SW-1:0] sel, input int wt, input logic [DW-1:0] rdata,
                       input bit er, input bit hold);
    int   n;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_sel   = sel;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: got cmd_ready=%0b after %0d cycles expected 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    acc_edge = cyc_cnt + 1;
    if (wt + 1 <= T) begin
      e.err  = er && ERR_EN;
      e.to   = 1'b0;
      e.data = (we || e.err) ? '0 : rdata;
      e.cyc  = acc_edge + wt + 1;
    end else begin
      e.err  = 1'b0;
      e.to   = 1'b1;
      e.data = '0;
      e.cyc  = acc_edge + T;
    end
    @(posedge clk);
    cur_we    = we;
    cur_adr   = addr;
    cur_dat   = data;
    cur_sel   = sel;
    cur_wait  = wt;
    cur_rdata = rdata;
    cur_err   = er && ERR_EN;
    exp_q.push_back(e);
    #1;
    cmd_we   = $urandom_range(0, 1);
    cmd_addr = AW'($urandom);
    cmd_data = $urandom;
    cmd_sel  = SW'($urandom);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, e2, r, wt;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    cmd_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_wb",      {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o}, 64'd0);
    chk("rst_wbdat",   wbm_dat_o, 64'd0);
    chk("rst_rsp",     {rsp_valid, rsp_timeout, rsp_err, cmd_ready}, 64'd0);
    chk("rst_rspdata", rsp_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 64'd1);

    // Directed: zero-wait write, 3-wait read, never-ack timeout.
    issue(1'b1, 8'h00, 32'hEEEEEEEE, 4'hF, 0, 32'h0, 1'b0, 1'b0);
    drain();
    issue(1'b0, 8'h01, 32'h0, 4'hF, 3, 32'h12345678, 1'b0, 1'b0);
    drain();
    issue(1'b0, 8'h02, 32'h0, 4'hF, NEVER, 32'hCAFEF00D, 1'b0, 1'b0);
    drain();
    issue(1'b0, 8'h03, 32'h0, 4'h3, 15, 32'hA5A5A5A5, 1'b0, 1'b0);
    drain();
    issue(1'b1, 8'h04, 32'h01020304, 4'h5, 16, 32'h0, 1'b0, 1'b0);
    drain();
    if (ERR_EN) begin
      issue(1'b0, 8'h05, 32'h0, 4'hF, 2, 32'hDEADBEEF, 1'b1, 1'b0);
      drain();
    end

    // Back-to-back with valid held high.
    issue(1'b1, 8'h10, 32'h11111111, 4'hF, 0, 32'h0, 1'b0, 1'b1);
    e0 = acc_edge;
    issue(1'b0, 8'h11, 32'h0, 4'hF, 0, 32'h22222222, 1'b0, 1'b1);
    e1 = acc_edge;
    issue(1'b0, 8'h12, 32'h0, 4'hF, 0, 32'h33333333, 1'b0, 1'b0);
    e2 = acc_edge;
    chk("b2b_gap1", 64'(e1 - e0), 64'd3);
    chk("b2b_gap2", 64'(e2 - e1), 64'd3);
    drain();

    // Spurious ack/err while idle.
    spur_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_idle", {wbm_cyc_o, cmd_ready}, 64'd1);
    end
    spur_ack = 1'b0;
    @(negedge clk);

    // Reset in the middle of a bus cycle.
    issue(1'b0, 8'h20, 32'h0, 4'hF, NEVER, 32'h0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_bus_cyc", wbm_cyc_o, 64'd1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_wb",      {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o}, 64'd0);
    chk("midrst_wbdat",   wbm_dat_o, 64'd0);
    chk("midrst_rsp",     {rsp_valid, rsp_timeout, rsp_err, cmd_ready}, 64'd0);
    chk("midrst_rspdata", rsp_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", cmd_ready, 64'd1);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       wt = $urandom_range(0, 4);
      else if (r == 7) wt = T - 1;
      else if (r == 8) wt = T;
      else             wt = NEVER;
      issue($urandom_range(0, 1), AW'($urandom), $urandom, SW'($urandom), wt, $urandom,
            ($urandom_range(0, 4) == 0), (i != 39) && ($urandom_range(0, 1) == 1));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
